// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a registered carry chain.
// Optional condition-code flags (zf, sf, of) enabled by defining ADD_SEQ_FLAGS_EN.
module add_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef ADD_SEQ_FLAGS_EN
    ,
    output logic             zf,
    output logic             sf,
    output logic             of
`endif
);

    localparam int unsigned STEPS = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((WIDTH % CHUNK) != 0) begin : gen_bad_chunk
        $error("add_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ADD_SEQ_FLAGS_EN
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;
    logic             of_q, of_d;
`endif

    logic [31:0]      off;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_res;
    logic             last;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        co_d      = co_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef ADD_SEQ_FLAGS_EN
        zf_d      = zf_q;
        sf_d      = sf_q;
        of_d      = of_q;
`endif
        off       = 32'(cnt_q) * CHUNK;
        chunk_a   = a_q[off +: CHUNK];
        chunk_b   = b_q[off +: CHUNK];
        chunk_res = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        last      = (cnt_q == CNT_W'(STEPS - 1));

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    // Subtraction is a + ~b + 1, so invert b and force the carry-in.
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    sum_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sum_d[off +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d             = chunk_res[CHUNK];
                cnt_d               = cnt_q + 1'b1;
                if (last) begin
                    co_d    = chunk_res[CHUNK];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
`ifdef ADD_SEQ_FLAGS_EN
                    zf_d    = (sum_d == '0);
                    sf_d    = sum_d[WIDTH-1];
                    of_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ADD_SEQ_FLAGS_EN
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ADD_SEQ_FLAGS_EN
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign co   = co_q;
`ifdef ADD_SEQ_FLAGS_EN
    assign zf   = zf_q;
    assign sf   = sf_q;
    assign of   = of_q;
`endif

endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Parametrised multi-cycle adder/subtractor for the ALU; successor to the 1-bit full adder.
- Processes CHUNK bits per clock through a registered carry chain, so a WIDTH-bit add/sub completes in WIDTH/CHUNK cycles.
- Start/busy/done handshake.
- Produces sum, carry-out and Y86-64 condition-code flags (zf, sf, of) for the execute stage.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  1  0 = add (a+b+cin), 1 = subtract (a-b)
- a  input  WIDTH  operand A, sampled on accept edge
- b  input  WIDTH  operand B, sampled on accept edge
- cin  input  1  carry-in for add; ignored for subtract
- busy  output  1  high while computing
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, held until next accept
- co  output  1  carry-out of bit WIDTH-1
- zf  output  1  sum == 0 (only with ADD_SEQ_FLAGS_EN)
- sf  output  1  sum[WIDTH-1] (only with ADD_SEQ_FLAGS_EN)
- of  output  1  signed overflow (only with ADD_SEQ_FLAGS_EN)

Behaviour:
- STEPS = WIDTH/CHUNK. Elaboration fails (generate-time error) if WIDTH % CHUNK != 0.
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, co=0, zf=0, sf=0, of=0.
  - Chunk counter and internal carry cleared.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1 (accept edge):
  - Latch a, and b or ~b according to op.
  - Internal carry = cin (add) or 1 (sub).
  - cnt=0, busy=1, sum cleared, state->RUN.
- DONE, start=0: -> IDLE.
- DONE lasts exactly one cycle; done=1 only in DONE.
- RUN, each edge:
  - Add chunk cnt: a[cnt*CHUNK +: CHUNK] + b'[...] + carry.
  - Write the chunk result into sum[cnt*CHUNK +: CHUNK].
  - Carry register takes that chunk's carry-out; cnt++.
- RUN, edge with cnt == STEPS-1:
  - co = final carry.
  - Flags computed from the full sum.
  - busy=0, state->DONE.
- Latency: accept at edge N gives done=1 in the cycle after edge N+STEPS. Defaults: 8 cycles.
- start while busy=1: ignored, with no effect on the current operation.
- start in DONE: accepted. The done pulse still occurs that cycle, and the next op begins.
- a, b, op, cin may change freely after the accept edge.
- Subtract: co=1 means no borrow (a >= b unsigned). Y86 does not use co.
- of = (a'[W-1] == b'[W-1]) && (sum[W-1] != a'[W-1]), where a', b' are the latched (post-inversion) operands.
- Reset mid-RUN: operation aborted and no done pulse; outputs return to reset values on that edge.
- CHUNK == WIDTH: single RUN cycle, latency 1.

Optional Feature:
- Macro: ADD_SEQ_FLAGS_EN.
- Defined:
  - zf, sf and of ports exist.
  - They update only on the final RUN edge and hold with sum.
- Undefined:
  - zf, sf and of ports and their logic are omitted.
  - sum, co, busy and done behave identically.

Test Plan:
- Add, defaults (64/8): a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0, op=0 -> after 8 cycles: done pulse, sum=0, co=1, zf=1, sf=0, of=0.
- Signed overflow: a=64'h7FFF_FFFF_FFFF_FFFF, b=1, op=0 -> sum=64'h8000_0000_0000_0000, co=0, sf=1, of=1, zf=0.
- Subtract: a=5, b=7, op=1 -> sum=64'hFFFF_FFFF_FFFF_FFFE, co=0, sf=1, of=0. Then a=7, b=5 -> sum=2, co=1.
- Handshake:
  - Pulse start with a=3, b=4.
  - Assert start with a=100, b=100 at cycle 3 of RUN -> ignored; sum=7 at done.
  - Start held high in the DONE cycle -> second op accepted; sum=8 after 8 more cycles.
- Reset mid-op: rst=1 at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, co=0. No done pulse follows; a new op then completes normally.
- Parameter sweep: WIDTH=8 with CHUNK=1, 4 and 8, random a/b/cin/op against a reference a+b+cin / a-b -> sum/co/flags match; latency of 8, 2 and 1 cycles respectively.
